// File: rtl/mem_port_arbiter_pkg.sv
// Shared widths and FSM state encoding for the memory port arbiter.
package mem_port_arbiter_pkg;

  localparam int PKG_DW     = 16;  // array word width
  localparam int PKG_AW     = 4;   // row address width (16 rows)
  localparam int PKG_MEM_AW = 12;  // array address port width
  localparam int MEM_DEPTH  = 16;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ACCESS = 2'd1,
    ST_RESP   = 2'd2
  } state_t;

endpackage

// File: rtl/mem_port_arbiter_rr_grant.sv
// Round-robin one-hot picker: first valid requester starting at i_ptr, wrapping mod NREQ.
module rr_grant #(
  parameter int NREQ = 2,
  parameter int PW   = 1
) (
  input  logic [NREQ-1:0] i_valid,
  input  logic [PW-1:0]   i_ptr,
  output logic [NREQ-1:0] o_grant,
  output logic [PW-1:0]   o_idx,
  output logic            o_any
);

  // Scan ptr, ptr+1, ... and stop at the first valid requester.
  always_comb begin
    int j;
    o_grant = '0;
    o_idx   = '0;
    o_any   = 1'b0;
    j       = 0;
    for (int k = 0; k < NREQ; k++) begin
      j = int'(i_ptr) + k;
      if (j >= NREQ) j = j - NREQ;
      if (!o_any && i_valid[j]) begin
        o_grant[j] = 1'b1;
        o_idx      = j[PW-1:0];
        o_any      = 1'b1;
      end
    end
  end

endmodule

// File: rtl/mem_port_arbiter.sv
// Round-robin arbiter sharing one 16x16 DFF array between NREQ requesters.
// Each access is IDLE -> ACCESS -> RESP. Array strobes come from a falling-edge
// flop so they never move while clk is high and the array's gated row clock
// rises cleanly on the ACCESS->RESP edge.
//
//   state     | meaning
//   ST_IDLE   | offering a grant; handshake latches the request
//   ST_ACCESS | address/data stable; strobes launched at mid-cycle
//   ST_RESP   | write committed / read data captured; rsp_valid pulse
module mem_port_arbiter
  import mem_port_arbiter_pkg::*;
#(
  parameter int NREQ   = 2,
  parameter int DW     = PKG_DW,
  parameter int AW     = PKG_AW,
  parameter int MEM_AW = PKG_MEM_AW
) (
  input  logic              i_clk,
  input  logic              i_rst,
  input  logic [NREQ-1:0]   i_req_valid,
  output logic [NREQ-1:0]   o_req_ready,
  input  logic [NREQ-1:0]   i_req_we,
  input  logic [NREQ*AW-1:0] i_req_addr,
  input  logic [NREQ*DW-1:0] i_req_wdata,
  output logic [NREQ-1:0]   o_rsp_valid,
  output logic [DW-1:0]     o_rsp_rdata,
  output logic              o_busy,
  output logic [MEM_AW-1:0] o_mem_addr,
  output logic [DW-1:0]     o_mem_din,
  input  logic [DW-1:0]     i_mem_dout,
  output logic              o_mem_cs,
  output logic              o_mem_we
);

  localparam int PW = (NREQ > 1) ? $clog2(NREQ) : 1;
  localparam logic [PW-1:0] LAST_IDX = PW'(NREQ - 1);

  state_t          r_state;
  logic [PW-1:0]   r_rr_ptr;
  logic [PW-1:0]   r_grant_q;
  logic            r_we_q;
  logic [NREQ-1:0] r_rsp_valid;
  logic [DW-1:0]   r_rsp_rdata;
  logic [MEM_AW-1:0] r_mem_addr;
  logic [DW-1:0]   r_mem_din;
  logic            r_mem_cs;
  logic            r_mem_we;

  logic [NREQ-1:0] w_grant;
  logic [PW-1:0]   w_grant_idx;
  logic            w_any;
  logic            w_hs;
  logic [PW-1:0]   w_next_ptr;
  logic [AW-1:0]   w_sel_addr;
  logic [DW-1:0]   w_sel_wdata;
  logic            w_sel_we;
  logic [NREQ-1:0] w_one;

  rr_grant #(
    .NREQ (NREQ),
    .PW   (PW)
  ) u_rr_grant (
    .i_valid (i_req_valid),
    .i_ptr   (r_rr_ptr),
    .o_grant (w_grant),
    .o_idx   (w_grant_idx),
    .o_any   (w_any)
  );

  assign o_req_ready = (r_state == ST_IDLE) ? w_grant : '0;
  assign w_hs        = (r_state == ST_IDLE) && w_any;
  assign w_next_ptr  = (w_grant_idx == LAST_IDX) ? '0 : w_grant_idx + PW'(1);
  assign w_one       = {{(NREQ-1){1'b0}}, 1'b1};

  // Mux the winning requester's fields using the one-hot grant.
  always_comb begin
    w_sel_addr  = '0;
    w_sel_wdata = '0;
    w_sel_we    = 1'b0;
    for (int i = 0; i < NREQ; i++) begin
      if (w_grant[i]) begin
        w_sel_addr  = i_req_addr[i*AW +: AW];
        w_sel_wdata = i_req_wdata[i*DW +: DW];
        w_sel_we    = i_req_we[i];
      end
    end
  end

  // Transaction FSM with its datapath and response registers.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state     <= ST_IDLE;
      r_rr_ptr    <= '0;
      r_grant_q   <= '0;
      r_we_q      <= 1'b0;
      r_rsp_valid <= '0;
      r_rsp_rdata <= '0;
      r_mem_addr  <= '0;
      r_mem_din   <= '0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          r_rsp_valid <= '0;
          if (w_hs) begin
            r_mem_addr <= {{(MEM_AW-AW){1'b0}}, w_sel_addr};
            r_mem_din  <= w_sel_wdata;
            r_we_q     <= w_sel_we;
            r_grant_q  <= w_grant_idx;
            r_rr_ptr   <= w_next_ptr;
            r_state    <= ST_ACCESS;
          end
        end
        ST_ACCESS: begin
          // Write responses carry zero so stale array data never leaks out.
          r_rsp_rdata <= r_we_q ? '0 : i_mem_dout;
          r_rsp_valid <= w_one << r_grant_q;
          r_state     <= ST_RESP;
        end
        ST_RESP: begin
          r_rsp_valid <= '0;
          r_state     <= ST_IDLE;
        end
        default: begin
          r_rsp_valid <= '0;
          r_state     <= ST_IDLE;
        end
      endcase
    end
  end

  // Array strobes on the falling edge: high from mid-ACCESS to mid-RESP.
  always_ff @(negedge i_clk) begin
    if (i_rst) begin
      r_mem_cs <= 1'b0;
      r_mem_we <= 1'b0;
    end else begin
      r_mem_cs <= (r_state == ST_ACCESS);
      r_mem_we <= (r_state == ST_ACCESS) & r_we_q;
    end
  end

  assign o_rsp_valid = r_rsp_valid;
  assign o_rsp_rdata = r_rsp_rdata;
  assign o_busy      = (r_state != ST_IDLE);
  assign o_mem_addr  = r_mem_addr;
  assign o_mem_din   = r_mem_din;
  assign o_mem_cs    = r_mem_cs;
  assign o_mem_we    = r_mem_we;

endmodule
